// File: rtl/sub_seq.sv
// -----------------------------------------------------------------------------
// sub_seq -- multi-cycle subtractor with borrow-in.
//
// The block computes d = a - b - b_in as a + ~b + ~b_in and handles STEP bits
// per clock, LSB chunk first, with a registered carry linking the chunks. A
// result takes K = WIDTH/STEP RUN cycles. It is the area-lean subtract path
// that sits beside the combinational adder in the ALU datapath.
//
// Parameters
//   WIDTH  operand / result width (default 32)
//   STEP   bits handled per cycle (default 4); must divide WIDTH
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous, active-high reset
//   start  in   request; accepted only while ready = 1
//   a      in   minuend, sampled on the accepting edge
//   b      in   subtrahend, sampled on the accepting edge
//   b_in   in   borrow-in, sampled on the accepting edge
//   ready  out  high only in IDLE
//   done   out  one-cycle pulse in the cycle the results update
//   d      out  registered difference
//   b_out  out  borrow-out
//   zero   out  d == 0                (flag build only, else 0)
//   neg    out  d[WIDTH-1]            (flag build only, else 0)
//   ovf    out  signed overflow       (flag build only, else 0)
//
// Build option
//   SUB_SEQ_FLAGS_EN  when defined, zero/neg/ovf are computed and registered.
//                     When undefined they are constant 0, and the MSB
//                     carry-in tracking is not built.
// -----------------------------------------------------------------------------
module sub_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int K     = WIDTH / STEP;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_sh_q;
    logic               carry_q;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q;

    logic [STEP-1:0]    a_chunk;
    logic [STEP-1:0]    nb_chunk;
    logic [STEP:0]      chunk_sum;
    logic [WIDTH-1:0]   res_next;
    logic               last_chunk;

    // ------------------------------------------------------------------
    // Chunk arithmetic
    // ------------------------------------------------------------------
    assign a_chunk   = a_sh_q[STEP-1:0];
    assign nb_chunk  = ~b_sh_q[STEP-1:0];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, nb_chunk} + {{STEP{1'b0}}, carry_q};

    // Result is assembled MSB-side and shifted right, so after K chunks the
    // first (least significant) chunk has reached bit 0.
    assign res_next  = (res_sh_q >> STEP)
                     | (WIDTH'(chunk_sum[STEP-1:0]) << (WIDTH - STEP));

    assign last_chunk = (state_q == S_RUN) && (cnt_q == CNT_W'(K - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_chunk) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the registered state only
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE:  ready = 1'b1;
            S_DONE:  done  = 1'b1;
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                a_sh_q  <= a;
                b_sh_q  <= b;
                // Borrow-in enters as the inverted carry of a + ~b + ~b_in.
                carry_q <= ~b_in;
                cnt_q   <= '0;
            end else if (state_q == S_RUN) begin
                a_sh_q   <= a_sh_q >> STEP;
                b_sh_q   <= b_sh_q >> STEP;
                res_sh_q <= res_next;
                carry_q  <= chunk_sum[STEP];
                cnt_q    <= cnt_q + 1'b1;
                if (last_chunk) begin
                    d_q    <= res_next;
                    bout_q <= ~chunk_sum[STEP];
                end
            end
        end
    end

    assign d     = d_q;
    assign b_out = bout_q;

`ifdef SUB_SEQ_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ ~b ^ cin.
    assign msb_cin = chunk_sum[STEP-1] ^ a_chunk[STEP-1] ^ nb_chunk[STEP-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_chunk) begin
            zero_q <= (res_next == '0);
            neg_q  <= res_next[WIDTH-1];
            ovf_q  <= msb_cin ^ chunk_sum[STEP];
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule
